// File: rtl/fp_unpack_pipe.sv
// Two-stage IEEE-754 unpacker: field split and classification, then subnormal normalisation.
// Define FP_UNPACK_DAZ_EN to treat subnormal inputs as zero, which drops the LZC/shifter.
module fp_unpack_pipe #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_fp,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [EXP_W+1:0]       out_exp,
    output logic [MAN_W:0]         out_man,
    output logic                   out_is_nan,
    output logic                   out_is_inf,
    output logic                   out_is_zero,
    output logic                   out_is_denorm,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int XW   = EXP_W + 2;
    localparam int SH_W = $clog2(MAN_W + 1);
    localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);

    // Handshake: a beat moves on a cycle where valid and ready are both high; each
    // stage loads when it is empty or its content leaves downstream the same cycle.
    logic s1_valid_q, s2_valid_q;
    logic s1_load, s2_load;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // Field split and classification of the incoming operand.
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    logic             exp_ones, exp_zero, man_zero;
    logic             nan_d, inf_d, zero_d, denorm_d;

    assign in_sign  = in_fp[EXP_W+MAN_W];
    assign in_exp   = in_fp[EXP_W+MAN_W-1:MAN_W];
    assign in_man   = in_fp[MAN_W-1:0];
    assign exp_ones = &in_exp;
    assign exp_zero = ~|in_exp;
    assign man_zero = ~|in_man;
    assign nan_d    = exp_ones && !man_zero;
    assign inf_d    = exp_ones && man_zero;
`ifdef FP_UNPACK_DAZ_EN
    assign zero_d   = exp_zero;
    assign denorm_d = 1'b0;
`else
    assign zero_d   = exp_zero && man_zero;
    assign denorm_d = exp_zero && !man_zero;
`endif

    logic             s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_denorm_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [MAN_W-1:0] s1_man_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_man_q    <= '0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_denorm_q <= 1'b0;
            s1_tag_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= in_sign;
                s1_exp_q    <= in_exp;
                s1_man_q    <= in_man;
                s1_nan_q    <= nan_d;
                s1_inf_q    <= inf_d;
                s1_zero_q   <= zero_d;
                s1_denorm_q <= denorm_d;
                s1_tag_q    <= in_tag;
            end
        end
    end

    logic [XW-1:0] s2_exp_d;
    logic [MAN_W:0] s2_man_d;

`ifdef FP_UNPACK_DAZ_EN
    // Subnormals were already folded into zero, so only the normal path remains.
`else
    // Shift so the highest set fraction bit lands on the hidden-bit position.
    logic [SH_W-1:0] shamt;
    always_comb begin
        shamt = '0;
        for (int i = 0; i < MAN_W; i++) begin
            if (s1_man_q[i]) shamt = SH_W'(MAN_W - i);
        end
    end
`endif

    always_comb begin
        s2_exp_d = '0;
        s2_man_d = '0;
        if (!(s1_nan_q || s1_inf_q || s1_zero_q)) begin
            s2_exp_d = {2'b00, s1_exp_q} - BIAS;
            s2_man_d = {1'b1, s1_man_q};
`ifdef FP_UNPACK_DAZ_EN
`else
            if (s1_denorm_q) begin
                s2_exp_d = XW'(1) - BIAS - XW'(shamt);
                s2_man_d = {1'b0, s1_man_q} << shamt;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            out_sign      <= 1'b0;
            out_exp       <= '0;
            out_man       <= '0;
            out_is_nan    <= 1'b0;
            out_is_inf    <= 1'b0;
            out_is_zero   <= 1'b0;
            out_is_denorm <= 1'b0;
            out_tag       <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sign      <= s1_sign_q;
                out_exp       <= s2_exp_d;
                out_man       <= s2_man_d;
                out_is_nan    <= s1_nan_q;
                out_is_inf    <= s1_inf_q;
                out_is_zero   <= s1_zero_q;
                out_is_denorm <= s1_denorm_q;
                out_tag       <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;

endmodule

// File: doc/fp_unpack_pipe.md
Name: fp_unpack_pipe

Overview:
- Parametrised, pipelined IEEE-754 unpacker for any binary format (half, single, double).
- Splits each operand into sign, unbiased exponent, significand and class flags.
- Normalises subnormals, so the significand MSB is always 1 for non-special values.
- Sits at the front of the FP arithmetic pipelines and uses valid/ready handshakes on both sides, so it can stall under downstream backpressure.

Parameters:
- EXP_W, 11, exponent field width.
- MAN_W, 52, stored fraction width (no hidden bit).
- TAG_W, 4, width of the sideband tag carried alongside each operand.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_fp  input  1+EXP_W+MAN_W  packed IEEE operand.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  sign bit.
- out_exp  output  EXP_W+2  two's-complement unbiased exponent.
- out_man  output  MAN_W+1  significand, hidden bit at MSB.
- out_is_nan  output  1  input was a NaN.
- out_is_inf  output  1  input was an infinity.
- out_is_zero  output  1  input was a zero.
- out_is_denorm  output  1  input was a subnormal (flag reflects the input, even after normalisation).
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Bias = 2^(EXP_W-1)-1. Fields: sign = in_fp[MSB]; raw_exp = next EXP_W bits; raw_man = low MAN_W bits.
- Classification:
  - nan = exp all-ones and man != 0.
  - inf = exp all-ones and man == 0.
  - zero = exp 0 and man == 0.
  - denorm = exp 0 and man != 0.
- Normal values: out_exp = raw_exp - bias; out_man = {1, raw_man}.
- Subnormal values:
  - s = leading-zero count of raw_man + 1, so 1 ≤ s ≤ MAN_W.
  - out_man = {0, raw_man} << s, so the MSB is 1.
  - out_exp = 1 - bias - s.
- Special values (nan, inf, zero): out_exp = 0, out_man = 0. Sign is always passed through, including -0 and -inf.
- Pipeline has two register stages:
  - S1 registers the fields, the class flags and the tag.
  - S2 registers the LZC/shift result.
  - Each stage has its own valid bit.
- Latency: an accepted input appears on out_valid exactly 2 cycles later when there is no stall. Throughput is one operand per cycle.
- Advance rules:
  - S2 loads when !s2_valid or out_ready.
  - S1 loads when !s1_valid or S2 loads.
  - in_ready = !s1_valid or S2 loads. This is a combinational path from out_ready, which is acceptable.
- Transfer: an input is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Stability under stall: while out_valid & !out_ready, every out_* signal holds stable.
- Bubbles: a stage that loads while its upstream is invalid clears its valid bit. Its data registers may hold stale values, but out_* are only meaningful while out_valid = 1.
- Simultaneous events: consume and accept in the same cycle is legal; no bubble is inserted and no data is lost.
- Reset (asynchronous, may occur mid-operation):
  - s1_valid and s2_valid = 0, so out_valid = 0.
  - All data registers = 0.
  - In-flight operands are discarded.
  - in_ready = 1 in the first cycle after reset release.
- Exponent width EXP_W+2 covers the minimum subnormal exponent (1-bias-MAN_W) for all standard formats.

Optional Feature:
- Macro: FP_UNPACK_DAZ_EN.
- When defined (denormals-are-zero):
  - Subnormal inputs are reported as zero: out_is_zero = 1, out_is_denorm = 0, out_exp = 0, out_man = 0.
  - Sign is preserved.
  - The LZC/shifter is omitted.
- When undefined: full subnormal normalisation, as described in Behaviour.

Test Plan:
- Default params, in_fp = 0x3FF0000000000000 with out_ready held 1 → out_valid 2 cycles after accept; sign 0, out_exp 0, out_man 0x10000000000000, all flags 0.
- Default params, in_fp = 0x0000000000000001 (DAZ off) → out_is_denorm 1, out_exp = -1074 (13'h1BCE), out_man 0x10000000000000.
- In_fp 0x7FF8000000000000 → out_is_nan 1. 0xFFF0000000000000 → out_is_inf 1, sign 1. 0x8000000000000000 → out_is_zero 1, sign 1. For all three, out_exp = 0 and out_man = 0.
- Backpressure: stream 5 tagged operands (tags 0..4) and hold out_ready = 0 for 4 cycles →
  - in_ready drops after 2 accepts.
  - Outputs are held stable during the stall.
  - After release, tags arrive in order 0..4 with no loss or duplication.
  - A back-to-back stream afterwards achieves 1 result per cycle.
- EXP_W = 8, MAN_W = 23: in_fp = 0x00400000 → out_exp = -127, out_man 0x800000, out_is_denorm 1. With FP_UNPACK_DAZ_EN defined → out_is_zero 1, out_man 0.
- Assert rst_n low while both stages hold data → out_valid drops immediately (asynchronously); after release, in_ready = 1 and no stale result is emitted.
